job_controller: RTL and testbench
=================================

# job_controller

Initiator for the go/kill/done worker handshake: accepts a job request from upstream, pulses `go` to the worker, watches for `done`, and aborts the worker with `kill` on a cancel request or watchdog timeout. Retries timed-out jobs up to a limit, then reports a single-cycle `success` or `fail` pulse. Sits between the sequencing logic and one worker state machine.

## Interface
- `TIMEOUT`, default 128: cycles spent in WAIT before a watchdog kill. Range 2..255.
- `MAX_RETRY`, default 2: retries allowed after a timeout. Range 0..3.
- `KILL_HOLD`, default 2: cycles `kill` is held high. Range 1..15.

Ports:
- `clk`  in  1  clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears every register immediately.
- `start`  in  1  job request; sampled only in IDLE.
- `cancel`  in  1  abort request; sampled in LAUNCH and WAIT.
- `done`  in  1  worker completion pulse; sampled only in WAIT.
- `go`  out  1  registered; high for exactly one cycle per attempt.
- `kill`  out  1  registered; high for `KILL_HOLD` cycles per abort.
- `busy`  out  1  high in every state except IDLE.
- `success`  out  1  one-cycle pulse when the job completes.
- `fail`  out  1  one-cycle pulse on cancel or when retries are exhausted.
- `retries`  out  2  retries used in the current job; cleared on `start`.

## Operation
- States: IDLE, LAUNCH, WAIT, KILL, RELEASE. All outputs decode from registered state and flags. No combinational path from inputs to outputs.
- IDLE: `start`=1 → LAUNCH, clear `retries` and the cancel flag. `cancel` is ignored.
- LAUNCH: `go`=1 for this cycle only. `cancel`=1 → KILL with the cancel flag set. Otherwise → WAIT with the timer cleared to 0.
- WAIT: the timer increments by 1 each cycle (8-bit, no wrap because of the range limit).
  - Priority order: `done`=1 → IDLE, pulse `success`.
  - Else `cancel`=1 → KILL, set the cancel flag.
  - Else timer == `TIMEOUT`-1 → KILL (timeout).
- KILL: `kill`=1. Hold counter runs from 0. After `KILL_HOLD` cycles → RELEASE.
- RELEASE: `kill`=0 for one cycle so the worker returns from abort to idle. Then:
  - If the cancel flag is set → IDLE, pulse `fail`.
  - Else if `retries` < `MAX_RETRY` → increment `retries`, go to LAUNCH.
  - Else → IDLE, pulse `fail`.
- `done` arriving in KILL, RELEASE, or IDLE is ignored.
- `start` while `busy` is ignored and not queued.
- `success` and `fail` are never high together. Each is high for exactly one cycle, the first cycle back in IDLE.

## Timing
- Reset values: state IDLE, `go`=0, `kill`=0, `busy`=0, `success`=0, `fail`=0, `retries`=0, timer=0. Reset mid-job drops `go`/`kill` at once, with no `fail` pulse.
- `start` sampled high at edge N: `busy` and `go` high after edge N, and `go` falls after edge N+1.
- Worker contract: the worker samples `go` at edge N+1, counts 100 active cycles, and returns `done` about 102 cycles after that. The default `TIMEOUT`=128 gives margin.
- Timeout kill: `kill` rises `TIMEOUT` cycles after WAIT entry. It is high for `KILL_HOLD` cycles, followed by 1 low cycle. A retry `go` follows on the next cycle.
- `done` in the same cycle as `cancel` or timeout expiry: `done` wins.
- Worst-case job length: (`MAX_RETRY`+1) × (1 + `TIMEOUT` + `KILL_HOLD` + 1) cycles.

## Structure
- Package `job_ctrl_pkg` holds the state encoding (3-bit localparams IDLE..RELEASE) and the parameter range limits.
- One natural sub-module, `cycle_timer`: an 8-bit clearable up-counter with an enable and a `hit` compare output.
  - It is instanced twice: the WAIT watchdog, compared against `TIMEOUT`-1, and the KILL hold counter, compared against `KILL_HOLD`-1.
- The FSM, retry counter and pulse registers live in `job_controller`.

## Test plan
- **Nominal:** `start` pulse, worker model returns `done` 102 cycles after `go`. Required: one `go` pulse, no `kill`, `success` high 1 cycle, `retries`=0, `busy` low afterwards.
- **Cancel:** `cancel` asserted 20 cycles into WAIT. Required: `kill` high exactly 2 cycles then 1 low cycle, `fail` pulses, no second `go`, `retries`=0.
- **Retry exhaustion:** worker never asserts `done`, defaults in place. Required: 3 `go` pulses spaced 132 cycles apart, 3 kill windows, `retries` ends at 2, a single `fail` pulse.
- **Race:** `done` and `cancel` high in the same WAIT cycle. Required: `success` pulses, `fail` stays 0, `kill` never rises.
- **Reset mid-KILL:** `reset` asserted while `kill`=1. Required: `kill`, `busy` and `retries` are 0 immediately. A new `start` after release runs a clean nominal job.
- **Protocol guards:** `start` held high continuously through a job, `done` injected in IDLE and RELEASE. Required: no extra `go` while busy, no spurious `success`. A new job launches the cycle after IDLE is re-entered with `start` still high.

Source files
------------

// File: rtl/job_ctrl_pkg.sv
// Shared definitions for the job controller: state encoding, parameter limits
// and a clamp helper used to keep parameters inside their legal ranges.
package job_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LAUNCH  = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_KILL    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_LAUNCH  = ST_LAUNCH,
        S_WAIT    = ST_WAIT,
        S_KILL    = ST_KILL,
        S_RELEASE = ST_RELEASE
    } state_e;

    localparam int TIMER_W       = 8;
    localparam int TIMEOUT_MIN   = 2;
    localparam int TIMEOUT_MAX   = 255;
    localparam int MAX_RETRY_MIN = 0;
    localparam int MAX_RETRY_MAX = 3;
    localparam int KILL_HOLD_MIN = 1;
    localparam int KILL_HOLD_MAX = 15;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/job_controller_cycle_timer.sv
// 8-bit clearable up-counter with enable; hit_o flags when the count equals limit_i.
module cycle_timer
    import job_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [TIMER_W-1:0] limit_i,
    output logic               hit_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Clear dominates so the count is already 0 on the first enabled cycle.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit_o = (count_q == limit_i);

endmodule

// File: rtl/job_controller.sv
// Initiator side of the go/kill/done worker handshake with watchdog timeout,
// bounded retries and single-cycle success/fail reporting.
module job_controller
    import job_ctrl_pkg::*;
#(
    parameter int TIMEOUT   = 128,
    parameter int MAX_RETRY = 2,
    parameter int KILL_HOLD = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cancel,
    input  logic       done,
    output logic       go,
    output logic       kill,
    output logic       busy,
    output logic       success,
    output logic       fail,
    output logic [1:0] retries
);

    localparam int TIMEOUT_C   = clamp(TIMEOUT,   TIMEOUT_MIN,   TIMEOUT_MAX);
    localparam int MAX_RETRY_C = clamp(MAX_RETRY, MAX_RETRY_MIN, MAX_RETRY_MAX);
    localparam int KILL_HOLD_C = clamp(KILL_HOLD, KILL_HOLD_MIN, KILL_HOLD_MAX);

    localparam logic [TIMER_W-1:0] WD_LIMIT   = TIMER_W'(TIMEOUT_C - 1);
    localparam logic [TIMER_W-1:0] HOLD_LIMIT = TIMER_W'(KILL_HOLD_C - 1);
    localparam logic [1:0]         RETRY_LIM  = 2'(MAX_RETRY_C);

    state_e     state_q;
    logic       go_q;
    logic       kill_q;
    logic       success_q;
    logic       fail_q;
    logic       cancel_q;
    logic [1:0] retries_q;

    // Index 0 is the WAIT watchdog, index 1 the KILL hold counter.
    logic [1:0] tmr_run;
    logic [1:0] tmr_hit;

    assign tmr_run[0] = (state_q == S_WAIT);
    assign tmr_run[1] = (state_q == S_KILL);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_timer
            cycle_timer u_timer (
                .clk     (clk),
                .rst     (reset),
                .clr_i   (!tmr_run[gi]),
                .en_i    (tmr_run[gi]),
                .limit_i ((gi == 0) ? WD_LIMIT : HOLD_LIMIT),
                .hit_o   (tmr_hit[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            go_q      <= 1'b0;
            kill_q    <= 1'b0;
            success_q <= 1'b0;
            fail_q    <= 1'b0;
            cancel_q  <= 1'b0;
            retries_q <= '0;
        end else begin
            go_q      <= 1'b0;
            success_q <= 1'b0;
            fail_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_LAUNCH;
                        go_q      <= 1'b1;
                        retries_q <= '0;
                        cancel_q  <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    if (cancel) begin
                        state_q  <= S_KILL;
                        kill_q   <= 1'b1;
                        cancel_q <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // done beats both cancel and watchdog expiry in the same cycle
                    if (done) begin
                        state_q   <= S_IDLE;
                        success_q <= 1'b1;
                    end else if (cancel) begin
                        state_q  <= S_KILL;
                        kill_q   <= 1'b1;
                        cancel_q <= 1'b1;
                    end else if (tmr_hit[0]) begin
                        state_q <= S_KILL;
                        kill_q  <= 1'b1;
                    end
                end
                S_KILL: begin
                    if (tmr_hit[1]) begin
                        state_q <= S_RELEASE;
                        kill_q  <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    if (cancel_q) begin
                        state_q <= S_IDLE;
                        fail_q  <= 1'b1;
                    end else if (retries_q < RETRY_LIM) begin
                        state_q   <= S_LAUNCH;
                        go_q      <= 1'b1;
                        retries_q <= retries_q + 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        fail_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    kill_q  <= 1'b0;
                end
            endcase
        end
    end

    assign go      = go_q;
    assign kill    = kill_q;
    assign busy    = (state_q != S_IDLE);
    assign success = success_q;
    assign fail    = fail_q;
    assign retries = retries_q;

endmodule

// File: tb/tb_job_controller.sv
// Directed bench for job_controller at default parameters (TIMEOUT=128,
// MAX_RETRY=2, KILL_HOLD=2) with hand-computed expected cycle counts.
module tb_job_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cancel;
    logic       done;
    logic       go;
    logic       kill;
    logic       busy;
    logic       success;
    logic       fail;
    logic [1:0] retries;

    int checks   = 0;
    int failures = 0;

    int go_cnt     = 0;
    int kill_cyc   = 0;
    int kill_rise  = 0;
    int succ_cnt   = 0;
    int fail_cnt   = 0;
    int both_cnt   = 0;
    logic kill_prev = 1'b0;

    job_controller dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cancel  (cancel),
        .done    (done),
        .go      (go),
        .kill    (kill),
        .busy    (busy),
        .success (success),
        .fail    (fail),
        .retries (retries)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (go === 1'b1)                      go_cnt++;
            if (kill === 1'b1)                    kill_cyc++;
            if (kill === 1'b1 && kill_prev !== 1'b1) kill_rise++;
            if (success === 1'b1)                 succ_cnt++;
            if (fail === 1'b1)                    fail_cnt++;
            if (success === 1'b1 && fail === 1'b1) both_cnt++;
        end
        kill_prev = kill;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int n;
        int g0, k0, kr0, s0, f0;

        reset = 1'b1; start = 1'b0; cancel = 1'b0; done = 1'b0;
        tick();
        check("rst_go", go, 0);
        check("rst_kill", kill, 0);
        check("rst_busy", busy, 0);
        check("rst_success", success, 0);
        check("rst_fail", fail, 0);
        check("rst_retries", retries, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Nominal: done 102 cycles after go is sampled
        g0 = go_cnt; k0 = kill_cyc; s0 = succ_cnt; f0 = fail_cnt;
        start = 1'b1;
        tick();
        check("nom_go_rise", go, 1);
        check("nom_busy", busy, 1);
        start = 1'b0;
        tick();
        check("nom_go_fall", go, 0);
        repeat (100) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("nom_success", success, 1);
        check("nom_busy_low", busy, 0);
        check("nom_retries", retries, 0);
        tick();
        check("nom_success_1cyc", success, 0);
        check("nom_go_count", go_cnt - g0, 1);
        check("nom_kill_count", kill_cyc - k0, 0);
        check("nom_succ_count", succ_cnt - s0, 1);
        check("nom_fail_count", fail_cnt - f0, 0);

        // Cancel 20 cycles into WAIT
        g0 = go_cnt; k0 = kill_cyc; s0 = succ_cnt; f0 = fail_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (20) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("can_kill1", kill, 1);
        tick();
        check("can_kill2", kill, 1);
        tick();
        check("can_release_kill", kill, 0);
        check("can_release_busy", busy, 1);
        tick();
        check("can_fail", fail, 1);
        check("can_busy_low", busy, 0);
        check("can_retries", retries, 0);
        tick();
        check("can_fail_1cyc", fail, 0);
        check("can_go_count", go_cnt - g0, 1);
        check("can_kill_cycles", kill_cyc - k0, 2);
        check("can_succ_count", succ_cnt - s0, 0);

        // Retry exhaustion: worker never answers
        g0 = go_cnt; k0 = kill_cyc; kr0 = kill_rise; s0 = succ_cnt; f0 = fail_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rty_go0", go, 1);
        for (int a = 1; a <= 2; a++) begin
            n = 0;
            do begin tick(); n++; end while (go !== 1'b1 && n < 200);
            check($sformatf("rty_gap%0d", a), n, 132);
            check($sformatf("rty_retries%0d", a), retries, a);
        end
        n = 0;
        do begin tick(); n++; end while (fail !== 1'b1 && n < 300);
        check("rty_fail_gap", n, 132);
        check("rty_retries_end", retries, 2);
        check("rty_busy_low", busy, 0);
        tick();
        check("rty_fail_1cyc", fail, 0);
        check("rty_go_count", go_cnt - g0, 3);
        check("rty_kill_windows", kill_rise - kr0, 3);
        check("rty_kill_cycles", kill_cyc - k0, 6);
        check("rty_fail_count", fail_cnt - f0, 1);
        check("rty_succ_count", succ_cnt - s0, 0);

        // Race: done and cancel together
        kr0 = kill_rise; f0 = fail_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        done = 1'b1; cancel = 1'b1;
        tick();
        done = 1'b0; cancel = 1'b0;
        check("race_success", success, 1);
        check("race_fail", fail, 0);
        check("race_kill", kill, 0);
        repeat (4) tick();
        check("race_kill_rise", kill_rise - kr0, 0);
        check("race_fail_count", fail_cnt - f0, 0);

        // Race: done on the exact watchdog expiry cycle
        kr0 = kill_rise;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (127) tick();
        check("wdrace_no_kill_yet", kill, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("wdrace_success", success, 1);
        repeat (3) tick();
        check("wdrace_kill_rise", kill_rise - kr0, 0);

        // Reset while kill is high on the second attempt
        f0 = fail_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (retries !== 2'd1 && n < 400) begin tick(); n++; end
        check("rstk_reach_retry", retries, 1);
        n = 0;
        while (kill !== 1'b1 && n < 200) begin tick(); n++; end
        check("rstk_reach_kill", kill, 1);
        #2 reset = 1'b1;
        #1;
        check("rstk_kill", kill, 0);
        check("rstk_busy", busy, 0);
        check("rstk_retries", retries, 0);
        check("rstk_fail", fail, 0);
        @(negedge clk);
        reset = 1'b0;
        g0 = go_cnt; s0 = succ_cnt; k0 = kill_cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rstk_new_go", go, 1);
        tick();
        repeat (100) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("rstk_new_success", success, 1);
        tick();
        check("rstk_go_count", go_cnt - g0, 1);
        check("rstk_kill_cycles", kill_cyc - k0, 0);
        check("rstk_fail_count", fail_cnt - f0, 0);

        // Protocol guards: done while idle, start held through a job
        s0 = succ_cnt;
        done = 1'b1;
        repeat (3) tick();
        done = 1'b0;
        check("grd_idle_done_succ", succ_cnt - s0, 0);
        check("grd_idle_done_busy", busy, 0);

        g0 = go_cnt; s0 = succ_cnt; f0 = fail_cnt;
        start = 1'b1;
        tick();
        check("grd_go1", go, 1);
        repeat (6) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        done = 1'b1;
        tick();
        tick();
        check("grd_release_kill", kill, 0);
        check("grd_release_busy", busy, 1);
        tick();
        check("grd_fail", fail, 1);
        check("grd_no_success", success, 0);
        check("grd_idle_busy", busy, 0);
        tick();
        done = 1'b0;
        start = 1'b0;
        check("grd_relaunch_go", go, 1);
        check("grd_relaunch_success", success, 0);
        tick();
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("grd_final_success", success, 1);
        tick();
        check("grd_go_count", go_cnt - g0, 2);
        check("grd_succ_count", succ_cnt - s0, 1);
        check("grd_fail_count", fail_cnt - f0, 1);
        check("both_never", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
